// File: rtl/game_pkg.sv
// game_pkg: shared types, widths and helpers for the game sequencer
package game_pkg;
  typedef enum logic [1:0] {TITLE, PLAY, WIN1, WIN2} state_t;
  localparam int SCORE_W = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int MAX_FISH = 32;
  function automatic logic [SCORE_W-1:0] popcount(input logic [MAX_FISH-1:0] v);
    logic [SCORE_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_FISH; i++) c += SCORE_W'(v[i]);
    return c;
  endfunction
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b,
                                                 input logic [SCORE_W-1:0] lim);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, lim}) ? lim : s[SCORE_W-1:0];
  endfunction
endpackage

// File: rtl/fish_respawn_timer.sv
// fish_respawn_timer: hidden flag plus down-counter for one fish sprite
module fish_respawn_timer
  import game_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic clear,
  input  logic eat,
  output logic exist
);
  // a zero respawn time still hides the fish for one tick
  localparam logic [FRAME_CNT_W-1:0] LOAD =
    (RESPAWN_FRAMES < 1) ? FRAME_CNT_W'(1) : FRAME_CNT_W'(RESPAWN_FRAMES);
  logic [FRAME_CNT_W-1:0] cnt;
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      exist <= 1'b0;
      cnt   <= '0;
    end else if (tick && eat && !exist) begin
      exist <= 1'b1;
      cnt   <= LOAD;
    end else if (tick && exist) begin
      cnt   <= cnt - 1'b1;
      exist <= (cnt != FRAME_CNT_W'(1));
    end
  end
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: title/play/win sequencer with scoring, fish respawn and player liveness
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_FISH        = 9,
  parameter int WIN_SCORE       = 9,
  parameter int RESPAWN_FRAMES  = 120,
  parameter int WIN_HOLD_FRAMES = 300
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                start_key,
  input  logic [NUM_FISH-1:0] hit1,
  input  logic [NUM_FISH-1:0] hit2,
  input  logic                shark_hit1,
  input  logic                shark_hit2,
  output logic                is_start,
  output logic                is_user1win,
  output logic                is_user2win,
  output logic [SCORE_W-1:0]  score1,
  output logic [SCORE_W-1:0]  score2,
  output logic [NUM_FISH-1:0] fish_exist,
  output logic                user1_exist,
  output logic                user2_exist
);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] HOLD = FRAME_CNT_W'(WIN_HOLD_FRAMES);
  state_t state, state_n;
  logic [1:0] frame_q, start_q;
  logic frame_tick, start_edge, play_tick, clear;
  logic [NUM_FISH-1:0] eat1, eat2;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic dead1_n, dead2_n, win1_ok, win2_ok, tie_break;
  logic [FRAME_CNT_W-1:0] hold, hold_n;

  assign frame_tick = frame_q[0] & ~frame_q[1];
  assign start_edge = start_q[0] & ~start_q[1];
  assign play_tick  = frame_tick && (state == PLAY);
  assign clear      = start_edge && (state == TITLE);

  // user1 has priority on a fish both players touch
  always_comb begin
    eat1      = hit1 & ~fish_exist & {NUM_FISH{~user1_exist}};
    eat2      = hit2 & ~fish_exist & ~eat1 & {NUM_FISH{~user2_exist}};
    score1_n  = sat_add(score1, popcount(MAX_FISH'(eat1)), WIN_S);
    score2_n  = sat_add(score2, popcount(MAX_FISH'(eat2)), WIN_S);
    dead1_n   = user1_exist | shark_hit1;
    dead2_n   = user2_exist | shark_hit2;
    win1_ok   = (score1_n >= WIN_S) || (dead2_n && !dead1_n);
    win2_ok   = (score2_n >= WIN_S) || (dead1_n && !dead2_n);
    tie_break = (win1_ok && win2_ok) || (dead1_n && dead2_n);
    state_n   = state;
    hold_n    = hold;
    case (state)
      TITLE: state_n = start_edge ? PLAY : TITLE;
      PLAY: if (frame_tick) begin
        state_n = tie_break ? ((score2_n > score1_n) ? WIN2 : WIN1) :
                  win1_ok ? WIN1 : win2_ok ? WIN2 : PLAY;
        hold_n  = (state_n != PLAY) ? HOLD : hold;
      end
      default: if (frame_tick) begin
        state_n = (hold <= FRAME_CNT_W'(1)) ? TITLE : state;
        hold_n  = (hold == '0) ? hold : hold - 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= TITLE;
      frame_q     <= '0;
      start_q     <= '0;
      hold        <= '0;
      is_start    <= 1'b0;
      is_user1win <= 1'b0;
      is_user2win <= 1'b0;
      score1      <= '0;
      score2      <= '0;
      user1_exist <= 1'b0;
      user2_exist <= 1'b0;
    end else begin
      frame_q     <= {frame_q[0], frame_clk};
      start_q     <= {start_q[0], start_key};
      state       <= state_n;
      hold        <= hold_n;
      is_start    <= (state_n != TITLE);
      is_user1win <= (state_n == WIN1);
      is_user2win <= (state_n == WIN2);
      if (clear) begin
        score1      <= '0;
        score2      <= '0;
        user1_exist <= 1'b0;
        user2_exist <= 1'b0;
      end else if (play_tick) begin
        score1      <= score1_n;
        score2      <= score2_n;
        user1_exist <= dead1_n;
        user2_exist <= dead2_n;
      end
    end
  end

  for (genvar i = 0; i < NUM_FISH; i++) begin : g_fish
    fish_respawn_timer #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_timer (
      .Clk  (Clk),
      .Reset(Reset),
      .tick (play_tick),
      .clear(clear),
      .eat  (eat1[i] | eat2[i]),
      .exist(fish_exist[i])
    );
  end
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: scoreboard bench with a behavioural game model
module tb_game_state_ctrl;
  localparam int NF = 9;
  localparam int T = 0, P = 1, W1 = 2, W2 = 3;
  logic clk = 0, rst = 1, frame_clk = 0, start_key = 0, shark_hit1 = 0, shark_hit2 = 0;
  logic [NF-1:0] hit1 = '0, hit2 = '0;
  logic is_start, is_user1win, is_user2win, user1_exist, user2_exist;
  logic [7:0] score1, score2;
  logic [NF-1:0] fish_exist;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .start_key(start_key),
    .hit1(hit1), .hit2(hit2), .shark_hit1(shark_hit1), .shark_hit2(shark_hit2),
    .is_start(is_start), .is_user1win(is_user1win), .is_user2win(is_user2win),
    .score1(score1), .score2(score2), .fish_exist(fish_exist),
    .user1_exist(user1_exist), .user2_exist(user2_exist)
  );

  typedef struct {
    int st; int s1; int s2; logic [NF-1:0] fe; logic u1; logic u2;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int m_st, m_s1, m_s2, m_hold;
  int m_cnt[NF];
  logic [NF-1:0] m_fe;
  logic m_u1, m_u2;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_fe = '0; m_u1 = 0; m_u2 = 0;
    for (int i = 0; i < NF; i++) m_cnt[i] = 0;
  endtask

  task automatic model_tick(input logic [NF-1:0] h1, input logic [NF-1:0] h2, input logic sh1, input logic sh2);
    int e1, e2;
    logic w1, w2;
    if (m_st == P) begin
      e1 = 0; e2 = 0;
      for (int i = 0; i < NF; i++) begin
        if (m_fe[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) m_fe[i] = 0;
        end else if (h1[i] && !m_u1) begin
          m_fe[i] = 1; m_cnt[i] = 120; e1++;
        end else if (h2[i] && !m_u2) begin
          m_fe[i] = 1; m_cnt[i] = 120; e2++;
        end
      end
      m_s1 = (m_s1 + e1 > 9) ? 9 : m_s1 + e1;
      m_s2 = (m_s2 + e2 > 9) ? 9 : m_s2 + e2;
      m_u1 = m_u1 | sh1;
      m_u2 = m_u2 | sh2;
      w1 = (m_s1 >= 9) || (m_u2 && !m_u1);
      w2 = (m_s2 >= 9) || (m_u1 && !m_u2);
      if ((w1 && w2) || (m_u1 && m_u2)) m_st = (m_s2 > m_s1) ? W2 : W1;
      else if (w1) m_st = W1;
      else if (w2) m_st = W2;
      if (m_st != P) m_hold = 300;
    end else if (m_st == W1 || m_st == W2) begin
      m_hold--;
      if (m_hold == 0) m_st = T;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.st = m_st; e.s1 = m_s1; e.s2 = m_s2; e.fe = m_fe; e.u1 = m_u1; e.u2 = m_u2;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard: output observed with empty queue at %0t", $time);
      return;
    end
    e = sb.pop_front();
    check("is_start", is_start, int'(e.st != T));
    check("is_user1win", is_user1win, int'(e.st == W1));
    check("is_user2win", is_user2win, int'(e.st == W2));
    check("score1", score1, e.s1);
    check("score2", score2, e.s2);
    check("fish_exist", fish_exist, e.fe);
    check("user1_exist", user1_exist, e.u1);
    check("user2_exist", user2_exist, e.u2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start_key = 0;
    m_st = T; m_hold = 0; model_clear();
    push_exp();
    @(negedge clk);
    compare_out();
    rst = 0;
  endtask

  task automatic press_start();
    logic fresh;
    @(negedge clk);
    fresh = !start_key && m_st == T;
    if (fresh) begin m_st = P; model_clear(); end
    start_key = 1;
    push_exp();
    @(negedge clk);
    if (fresh) check("start_latency", is_start, 0);
    @(negedge clk);
    compare_out();
  endtask

  task automatic release_start();
    @(negedge clk);
    start_key = 0;
  endtask

  task automatic frame(input logic [NF-1:0] h1, input logic [NF-1:0] h2, input logic sh1, input logic sh2);
    @(negedge clk);
    hit1 = h1; hit2 = h2; shark_hit1 = sh1; shark_hit2 = sh2; frame_clk = 1;
    model_tick(h1, h2, sh1, sh2);
    push_exp();
    @(negedge clk);
    frame_clk = 0;
    @(negedge clk);
    hit1 = '0; hit2 = '0; shark_hit1 = 0; shark_hit2 = 0;
    compare_out();
  endtask

  initial begin
    logic [NF-1:0] r1, r2;
    do_reset();
    press_start();
    repeat (10) frame('0, '0, 0, 0);
    release_start();
    frame(9'b000000101, '0, 0, 0);
    repeat (120) frame('0, '0, 0, 0);
    frame(9'b000001000, 9'b000001000, 0, 0);
    frame(9'b111111000, '0, 0, 0);
    frame(9'b000000111, 9'b000000111, 0, 0);
    press_start();
    repeat (300) begin
      r1 = NF'($urandom); r2 = NF'($urandom);
      frame(r1, r2, 1'($urandom), 1'($urandom));
    end
    frame(9'b111111111, '0, 0, 0);
    release_start();
    press_start();
    release_start();
    frame('0, 9'b000011111, 0, 0);
    frame(9'b001100000, '0, 0, 0);
    frame('0, '0, 0, 1);
    repeat (2) frame('0, '0, 0, 0);
    do_reset();
    press_start();
    release_start();
    frame('0, 9'b000011111, 0, 0);
    frame(9'b001100000, '0, 0, 0);
    frame('0, '0, 1, 1);
    repeat (3) frame('0, '0, 0, 0);
    do_reset();
    press_start();
    release_start();
    frame(9'b000001111, '0, 0, 0);
    do_reset();
    frame(9'b111111111, '0, 0, 0);
    press_start();
    release_start();
    repeat (5) frame('0, '0, 0, 0);
    repeat (250) begin
      r1 = NF'($urandom) & NF'($urandom);
      r2 = NF'($urandom) & NF'($urandom);
      frame(r1, r2, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
      if (m_st == T) begin press_start(); release_start(); end
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Game-level sequencer that runs title, play and win screens, and keeps both players' scores.
- Tracks eaten or respawning fish and player liveness.
- Sits directly upstream of the colour mapper. It drives the screen-select flags (is_start, is_user1win, is_user2win), score1/score2 and all *_exist hide flags.
- Consumes per-fish collision hits from the sprite/collision logic and the frame clock.

Parameters:
- NUM_FISH, 9, number of fish sprites tracked.
- WIN_SCORE, 9, score at which a player wins (fits a single displayed digit).
- RESPAWN_FRAMES, 120, frame ticks an eaten fish stays hidden.
- WIN_HOLD_FRAMES, 300, frame ticks a win screen is held before returning to title.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vertical-sync-rate frame strobe; sampled in the Clk domain.
- start_key  in  1  level, high while the start key is held.
- hit1  in  NUM_FISH  bit i high: user1 sprite overlaps fish i this frame.
- hit2  in  NUM_FISH  bit i high: user2 sprite overlaps fish i this frame.
- shark_hit1  in  1  user1 overlaps shark.
- shark_hit2  in  1  user2 overlaps shark.
- is_start  out  1  0 = title screen shown; 1 = game or win screen.
- is_user1win  out  1  1 = user1 win screen.
- is_user2win  out  1  1 = user2 win screen.
- score1  out  8  user1 score, binary, 0..WIN_SCORE.
- score2  out  8  user2 score, binary, 0..WIN_SCORE.
- fish_exist  out  NUM_FISH  bit i 1 = fish i hidden (eaten); 0 = drawn.
- user1_exist  out  1  1 = user1 dead/hidden.
- user2_exist  out  1  1 = user2 dead/hidden.

Behaviour:
- Reset values:
  - state TITLE; is_start=0, is_user1win=0, is_user2win=0.
  - score1=score2=0; fish_exist=0; user1_exist=user2_exist=0.
  - All respawn and hold counters 0.
- Reset mid-game or mid-win returns to TITLE on the next Clk with the values above.
- frame_tick: frame_clk registered twice; tick = (q1 & ~q2). It is a one-Clk pulse, 2 Clk after the frame_clk rise.
- All outputs are registered. Game updates take effect 1 Clk after frame_tick.
- start_key is edge-detected the same way (start_edge). Holding the key does not retrigger.
- FSM states: TITLE, PLAY, WIN1, WIN2.
- TITLE:
  - is_start=0.
  - On start_edge: go to PLAY, clear scores, fish_exist=0, userN_exist=0, clear respawn counters.
- PLAY, evaluated only on frame_tick:
  - Fish i is eatable when fish_exist[i]=0.
  - user1 eats it if hit1[i] & ~user1_exist. Otherwise user2 eats it if hit2[i] & ~user2_exist. If both hit, user1 gets the fish.
  - An eaten fish sets fish_exist[i]=1 and loads its counter with RESPAWN_FRAMES.
  - Scores add the per-frame count of fish each user ate (0..NUM_FISH), saturating at WIN_SCORE.
  - shark_hit1 sets user1_exist=1 (sticky until next game); same for shark_hit2 and user2. A shark hit and a fish hit in the same tick: the fish is scored, then the user dies.
- Respawn:
  - Each hidden fish decrements its counter on every frame_tick in PLAY.
  - The tick on which the counter goes 1→0 clears fish_exist[i].
  - A RESPAWN_FRAMES value of 0 is treated as 1.
- Win check, on the same tick, using post-update values:
  - If the new score1 ≥ WIN_SCORE or user2 is dead while user1 is alive → WIN1.
  - Symmetric condition → WIN2.
  - If both qualify, or both users are dead: the higher score wins; a tie goes to WIN1.
  - On entry, the hold counter is loaded with WIN_HOLD_FRAMES.
- WIN1/WIN2:
  - is_userNwin=1; scores and exist flags frozen; hit and start inputs ignored.
  - Hold counter decrements per tick; at 0 go to TITLE (scores retained until the next start).
- Frame_clk activity outside PLAY/WIN has no effect.

Decomposition:
- Package game_pkg holds:
  - the state enum (TITLE, PLAY, WIN1, WIN2);
  - SCORE_W=8 and the frame-count counter width constant;
  - a popcount function for NUM_FISH-wide vectors.
- One natural sub-module: fish_respawn_timer. It holds one hidden flag and a down-counter, with ports Clk, Reset, tick, clear, eat, exist. It is instantiated NUM_FISH times via generate.

Test Plan:
- Reset, then hold start_key 10 frames → one PLAY entry only. is_start=1 two Clk after the start edge; scores 0, fish_exist=0.
- PLAY, hit1=9'b000000101 for one frame → score1=2 and fish_exist[0], fish_exist[2] =1. After 120 ticks both bits return to 0 on the 120th tick.
- hit1[3]=hit2[3]=1 on the same tick → score1+1, score2 unchanged; fish 3 hidden.
- score1=8 and hit1 over 3 fish → score1=9 (saturated) and state WIN1 (is_user1win=1). After 300 ticks → TITLE (is_start=0).
- shark_hit2 with score1=2, score2=5 → user2_exist=1, WIN1. Both sharks hit on the same tick with score2=5 > score1=2 → WIN2.
- Synchronous Reset asserted mid-PLAY with score1=4 → next Clk: TITLE, scores 0, all exist flags 0, hidden fish counters cleared.
